// File: rtl/cmv_operand_seq.sv
// Operand sequencer for c_mac: streams A[row]·x term pairs row by row, clears the
// accumulator ahead of each row and republishes each row result with done/error status.
module cmv_operand_seq #(
    parameter int N       = 16,
    parameter int ROWS    = 4,
    parameter int K       = 4,
    parameter int TIMEOUT = 32,
    localparam int AW     = $clog2(ROWS * K),
    localparam int KW     = $clog2(K),
    localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    input  logic          a_wr_en,
    input  logic [AW-1:0] a_wr_addr,
    input  logic [N-1:0]  a_wr_r,
    input  logic [N-1:0]  a_wr_i,
    input  logic          x_wr_en,
    input  logic [KW-1:0] x_wr_addr,
    input  logic [N-1:0]  x_wr_r,
    input  logic [N-1:0]  x_wr_i,
    output logic          mac_clear,
    output logic          mac_en,
    output logic [N-1:0]  out_ar,
    output logic [N-1:0]  out_ai,
    output logic [N-1:0]  out_br,
    output logic [N-1:0]  out_bi,
    input  logic          mac_result_valid,
    input  logic [N-1:0]  mac_r_in,
    input  logic [N-1:0]  mac_i_in,
    output logic          y_valid,
    output logic [RW-1:0] y_idx,
    output logic [N-1:0]  y_r,
    output logic [N-1:0]  y_i,
    output logic [2:0]    dbg_state
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_CAPT  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t         state, state_n;
    logic [RW-1:0]  row, row_n;
    logic [KW-1:0]  k, k_n;
    logic [TW-1:0]  timer, timer_n;
    logic           error_n;
    logic [AW-1:0]  a_idx;

    logic [N-1:0] a_r_mem [ROWS*K];
    logic [N-1:0] a_i_mem [ROWS*K];
    logic [N-1:0] x_r_mem [K];
    logic [N-1:0] x_i_mem [K];

    assign dbg_state = state;

    // Register files only accept writes while idle so a running job sees a stable snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROWS * K; i++) begin
                a_r_mem[i] <= '0;
                a_i_mem[i] <= '0;
            end
            for (int i = 0; i < K; i++) begin
                x_r_mem[i] <= '0;
                x_i_mem[i] <= '0;
            end
        end else begin
            if (a_wr_en && state == S_IDLE && {1'b0, a_wr_addr} < (AW+1)'(ROWS * K)) begin
                a_r_mem[a_wr_addr] <= a_wr_r;
                a_i_mem[a_wr_addr] <= a_wr_i;
            end
            if (x_wr_en && state == S_IDLE && {1'b0, x_wr_addr} < (KW+1)'(K)) begin
                x_r_mem[x_wr_addr] <= x_wr_r;
                x_i_mem[x_wr_addr] <= x_wr_i;
            end
        end
    end

    always_comb begin
        state_n = state;
        row_n   = row;
        k_n     = k;
        timer_n = timer;
        error_n = error;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_CLEAR;
                    row_n   = '0;
                    error_n = 1'b0;
                end
            end
            S_CLEAR: begin
                state_n = S_ISSUE;
                k_n     = '0;
            end
            S_ISSUE: begin
                if (k == KW'(K - 1)) begin
                    state_n = S_WAIT;
                    timer_n = '0;
                end else begin
                    k_n = k + 1'b1;
                end
            end
            S_WAIT: begin
                if (mac_result_valid) begin
                    state_n = S_CAPT;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    state_n = S_ERR;
                    error_n = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            S_CAPT: begin
                if (row == RW'(ROWS - 1)) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_CLEAR;
                    row_n   = row + 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Operands are fetched with next-state counters so they line up with the registered mac_en.
    always_comb begin
        a_idx = AW'(row_n) * AW'(K) + AW'(k_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            row       <= '0;
            k         <= '0;
            timer     <= '0;
            error     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mac_clear <= 1'b0;
            mac_en    <= 1'b0;
            out_ar    <= '0;
            out_ai    <= '0;
            out_br    <= '0;
            out_bi    <= '0;
            y_valid   <= 1'b0;
            y_idx     <= '0;
            y_r       <= '0;
            y_i       <= '0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            k         <= k_n;
            timer     <= timer_n;
            error     <= error_n;
            busy      <= (state_n != S_IDLE);
            done      <= (state_n == S_DONE);
            mac_clear <= (state_n == S_CLEAR);
            mac_en    <= (state_n == S_ISSUE);
            if (state_n == S_ISSUE) begin
                out_ar <= a_r_mem[a_idx];
                out_ai <= a_i_mem[a_idx];
                out_br <= x_r_mem[k_n];
                out_bi <= x_i_mem[k_n];
            end else begin
                out_ar <= '0;
                out_ai <= '0;
                out_br <= '0;
                out_bi <= '0;
            end
            y_valid <= (state == S_CAPT);
            if (state == S_CAPT) begin
                y_idx <= row;
                y_r   <= mac_r_in;
                y_i   <= mac_i_in;
            end
        end
    end

endmodule

// File: tb/tb_cmv_operand_seq.sv
// Directed bench for cmv_operand_seq with a behavioural c_mac (Q8, result latency 6).
module tb_cmv_operand_seq;

    logic        clk, rst, start;
    logic        busy, done, error;
    logic        a_wr_en;
    logic [3:0]  a_wr_addr;
    logic [15:0] a_wr_r, a_wr_i;
    logic        x_wr_en;
    logic [1:0]  x_wr_addr;
    logic [15:0] x_wr_r, x_wr_i;
    logic        mac_clear, mac_en;
    logic [15:0] out_ar, out_ai, out_br, out_bi;
    logic        mac_result_valid;
    logic [15:0] mac_r_in, mac_i_in;
    logic        y_valid;
    logic [1:0]  y_idx;
    logic [15:0] y_r, y_i;
    logic [2:0]  dbg_state;

    int checks, errors;
    int nv, nd, done_cyc, first_busy, last_busy, err_cyc;
    int clr_cnt, en_cnt, first_clr, first_en, overlap, op_bad, order_bad, clr_row, en_row;
    int          y_cyc [4];
    logic [1:0]  y_idx_s [4];
    logic [15:0] y_r_s [4];
    logic [15:0] y_i_s [4];
    logic [15:0] en_ar_q [$];
    logic [15:0] en_br_q [$];
    bit tie_low, spurious;

    int          exp_cyc [4] = '{13, 25, 37, 49};
    logic [15:0] exp_id  [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    logic [15:0] exp_ord [4] = '{16'd30, 16'd70, 16'd110, 16'd150};

    cmv_operand_seq #(.N(16), .ROWS(4), .K(4), .TIMEOUT(32)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .a_wr_en(a_wr_en), .a_wr_addr(a_wr_addr), .a_wr_r(a_wr_r), .a_wr_i(a_wr_i),
        .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr), .x_wr_r(x_wr_r), .x_wr_i(x_wr_i),
        .mac_clear(mac_clear), .mac_en(mac_en),
        .out_ar(out_ar), .out_ai(out_ai), .out_br(out_br), .out_bi(out_bi),
        .mac_result_valid(mac_result_valid), .mac_r_in(mac_r_in), .mac_i_in(mac_i_in),
        .y_valid(y_valid), .y_idx(y_idx), .y_r(y_r), .y_i(y_i), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // c_mac stand-in: clear/accumulate on the DUT strobes, result_valid 6 cycles after the
    // 4th term, data one cycle later.
    initial begin
        int acc_r, acc_i, cd, ens, pr, pi;
        bit dp;
        acc_r = 0; acc_i = 0; cd = 0; ens = 0; dp = 0;
        mac_result_valid = 1'b0; mac_r_in = '0; mac_i_in = '0;
        forever begin
            @(negedge clk);
            mac_result_valid = 1'b0;
            if (rst) begin
                cd = 0; dp = 0;
            end else begin
                if (dp) begin
                    mac_r_in = 16'(acc_r); mac_i_in = 16'(acc_i); dp = 0;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0 && !tie_low) begin mac_result_valid = 1'b1; dp = 1; end
                end
                if (mac_clear) begin acc_r = 0; acc_i = 0; ens = 0; end
                if (mac_en) begin
                    pr = int'($signed(out_ar)) * int'($signed(out_br)) - int'($signed(out_ai)) * int'($signed(out_bi));
                    pi = int'($signed(out_ar)) * int'($signed(out_bi)) + int'($signed(out_ai)) * int'($signed(out_br));
                    acc_r += pr >>> 8;
                    acc_i += pi >>> 8;
                    ens++;
                    if (ens == 4) cd = 6;
                end
                if (spurious && mac_en) mac_result_valid = 1'b1;
            end
        end
    end

    task automatic write_a(input int addr, input logic [15:0] r, input logic [15:0] i);
        a_wr_en = 1'b1; a_wr_addr = 4'(addr); a_wr_r = r; a_wr_i = i;
        @(negedge clk);
        a_wr_en = 1'b0;
    endtask

    task automatic write_x(input int addr, input logic [15:0] r, input logic [15:0] i);
        x_wr_en = 1'b1; x_wr_addr = 2'(addr); x_wr_r = r; x_wr_i = i;
        @(negedge clk);
        x_wr_en = 1'b0;
    endtask

    task automatic load_identity();
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++)
                write_a(r * 4 + k, (r == k) ? 16'h0100 : 16'h0000, 16'h0000);
        for (int k = 0; k < 4; k++) write_x(k, 16'((k + 1) * 256), 16'h0000);
    endtask

    task automatic load_all_ones();
        for (int a = 0; a < 16; a++) write_a(a, 16'h0100, 16'h0100);
        for (int k = 0; k < 4; k++) write_x(k, 16'h0100, 16'h0000);
    endtask

    // Pulses start in cycle 0 and records what the DUT does in cycles 1..ncyc.
    task automatic run_job(input int ncyc, input bit disturb);
        nv = 0; nd = 0; done_cyc = 0; first_busy = 0; last_busy = 0; err_cyc = 0;
        clr_cnt = 0; en_cnt = 0; first_clr = 0; first_en = 0; overlap = 0; op_bad = 0;
        order_bad = 0; clr_row = 0; en_row = 0;
        for (int i = 0; i < 4; i++) begin
            y_cyc[i] = -1; y_idx_s[i] = 2'd3; y_r_s[i] = 16'hdead; y_i_s[i] = 16'hdead;
        end
        en_ar_q.delete(); en_br_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            if (y_valid) begin
                if (nv < 4) begin
                    y_cyc[nv] = cyc; y_idx_s[nv] = y_idx; y_r_s[nv] = y_r; y_i_s[nv] = y_i;
                end
                nv++; clr_row = 0; en_row = 0;
            end
            if (done) begin nd++; done_cyc = cyc; end
            if (busy) begin last_busy = cyc; if (first_busy == 0) first_busy = cyc; end
            if (error && err_cyc == 0) err_cyc = cyc;
            if (mac_clear) begin clr_cnt++; clr_row++; if (first_clr == 0) first_clr = cyc; end
            if (mac_en) begin
                en_cnt++;
                if (first_en == 0) first_en = cyc;
                if (en_row == 0 && clr_row != 1) order_bad++;
                en_row++;
                en_ar_q.push_back(out_ar); en_br_q.push_back(out_br);
            end
            if (mac_clear && mac_en) overlap++;
            if (!mac_en && {out_ar, out_ai, out_br, out_bi} != 64'd0) op_bad++;
            if (disturb && cyc >= 3 && cyc <= 20) begin
                start = (cyc % 2 == 1);
                a_wr_en = 1'b1; a_wr_addr = 4'd15; a_wr_r = 16'h7777; a_wr_i = 16'h1111;
                x_wr_en = 1'b1; x_wr_addr = 2'd3; x_wr_r = 16'h5555; x_wr_i = 16'h2222;
            end else begin
                start = 1'b0; a_wr_en = 1'b0; x_wr_en = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++; if ({busy, done, error, mac_clear, mac_en, y_valid} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, error, mac_clear, mac_en, y_valid}); end
        checks++; if ({out_ar, out_ai, out_br, out_bi, y_r, y_i} !== 96'd0) begin errors++; $display("FAIL reset_data: got %h want 0", {out_ar, out_ai, out_br, out_bi, y_r, y_i}); end
        checks++; if ({y_idx, dbg_state} !== 5'd0) begin errors++; $display("FAIL reset_state: got %b want 0", {y_idx, dbg_state}); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, dbg_state} !== 4'd0) begin errors++; $display("FAIL reset_idle: got %b want 0", {busy, dbg_state}); end
    endtask

    task automatic test_identity();
        load_identity();
        run_job(60, 1'b0);
        checks++; if (nv !== 4) begin errors++; $display("FAIL id_nvalid: got %0d want 4", nv); end
        checks++; if (nd !== 1 || done_cyc !== 49) begin errors++; $display("FAIL id_done: got n=%0d cyc=%0d want n=1 cyc=49", nd, done_cyc); end
        checks++; if (first_busy !== 1 || last_busy !== 49) begin errors++; $display("FAIL id_busy: got %0d..%0d want 1..49", first_busy, last_busy); end
        checks++; if (first_clr !== 1 || first_en !== 2) begin errors++; $display("FAIL id_first: got clr=%0d en=%0d want clr=1 en=2", first_clr, first_en); end
        checks++; if (clr_cnt !== 4 || en_cnt !== 16) begin errors++; $display("FAIL id_counts: got clr=%0d en=%0d want 4/16", clr_cnt, en_cnt); end
        checks++; if (overlap !== 0 || op_bad !== 0) begin errors++; $display("FAIL id_strobes: got overlap=%0d opnz=%0d want 0/0", overlap, op_bad); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (y_cyc[i] !== exp_cyc[i] || y_idx_s[i] !== 2'(i)) begin errors++; $display("FAIL id_strobe%0d: got cyc=%0d idx=%0d want cyc=%0d idx=%0d", i, y_cyc[i], y_idx_s[i], exp_cyc[i], i); end
            checks++; if (y_r_s[i] !== exp_id[i] || y_i_s[i] !== 16'h0000) begin errors++; $display("FAIL id_y%0d: got %h+j%h want %h+j0000", i, y_r_s[i], y_i_s[i], exp_id[i]); end
        end
    endtask

    task automatic test_all_ones();
        load_all_ones();
        run_job(60, 1'b0);
        checks++; if (nv !== 4 || nd !== 1) begin errors++; $display("FAIL ones_count: got nv=%0d nd=%0d want 4/1", nv, nd); end
        checks++; if (clr_cnt !== 4 || order_bad !== 0) begin errors++; $display("FAIL ones_clear: got clr=%0d bad_order=%0d want 4/0", clr_cnt, order_bad); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (y_r_s[i] !== 16'h0400 || y_i_s[i] !== 16'h0400) begin errors++; $display("FAIL ones_y%0d: got %h+j%h want 0400+j0400", i, y_r_s[i], y_i_s[i]); end
        end
    endtask

    task automatic test_timeout();
        tie_low = 1'b1;
        run_job(45, 1'b0);
        tie_low = 1'b0;
        checks++; if (en_cnt !== 4) begin errors++; $display("FAIL to_en: got %0d want 4", en_cnt); end
        checks++; if (err_cyc !== 38 || last_busy !== 38) begin errors++; $display("FAIL to_timing: got err=%0d busy_last=%0d want 38/38", err_cyc, last_busy); end
        checks++; if (nv !== 0 || nd !== 0) begin errors++; $display("FAIL to_silent: got nv=%0d nd=%0d want 0/0", nv, nd); end
        checks++; if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_sticky: got err=%b busy=%b want 1/0", error, busy); end
        run_job(55, 1'b0);
        checks++; if (err_cyc !== 0) begin errors++; $display("FAIL to_clear: error seen in cycle %0d want never", err_cyc); end
        checks++; if (nd !== 1 || y_r_s[3] !== 16'h0400) begin errors++; $display("FAIL to_rerun: got nd=%0d y3=%h want 1/0400", nd, y_r_s[3]); end
    endtask

    task automatic test_ignore_during_job();
        load_identity();
        run_job(70, 1'b1);
        checks++; if (nd !== 1 || nv !== 4 || last_busy !== 49) begin errors++; $display("FAIL ign_job: got nd=%0d nv=%0d busy_last=%0d want 1/4/49", nd, nv, last_busy); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (y_r_s[i] !== exp_id[i] || y_i_s[i] !== 16'h0000) begin errors++; $display("FAIL ign_y%0d: got %h+j%h want %h+j0000", i, y_r_s[i], y_i_s[i], exp_id[i]); end
        end
    endtask

    task automatic test_reset_mid_job();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (dbg_state !== 3'd3) begin errors++; $display("FAIL rst_pre: got state %0d want 3", dbg_state); end
        rst = 1'b1;
        #1;
        checks++; if ({busy, done, error, mac_clear, mac_en, y_valid, dbg_state} !== 9'd0) begin errors++; $display("FAIL rst_ctrl: got %b want 0", {busy, done, error, mac_clear, mac_en, y_valid, dbg_state}); end
        checks++; if ({out_ar, out_ai, out_br, out_bi, y_r, y_i} !== 96'd0) begin errors++; $display("FAIL rst_data: got %h want 0", {out_ar, out_ai, out_br, out_bi, y_r, y_i}); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_job(55, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (y_r_s[i] !== 16'h0000 || y_i_s[i] !== 16'h0000) begin errors++; $display("FAIL rst_zero_y%0d: got %h+j%h want 0", i, y_r_s[i], y_i_s[i]); end
        end
        load_identity();
        run_job(55, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++; if (y_r_s[i] !== exp_id[i] || y_i_s[i] !== 16'h0000) begin errors++; $display("FAIL rst_reload_y%0d: got %h+j%h want %h+j0000", i, y_r_s[i], y_i_s[i], exp_id[i]); end
        end
    endtask

    task automatic test_spurious_order();
        for (int a = 0; a < 16; a++) write_a(a, 16'(a + 1), 16'h0000);
        for (int k = 0; k < 4; k++) write_x(k, 16'((k + 1) * 256), 16'h0000);
        spurious = 1'b1;
        run_job(60, 1'b0);
        spurious = 1'b0;
        checks++; if (en_ar_q.size() !== 16 || nv !== 4 || done_cyc !== 49) begin errors++; $display("FAIL ord_count: got en=%0d nv=%0d done=%0d want 16/4/49", en_ar_q.size(), nv, done_cyc); end
        for (int j = 0; j < 16; j++) begin
            checks++; if (en_ar_q[j] !== 16'(j + 1) || en_br_q[j] !== 16'(((j % 4) + 1) * 256)) begin errors++; $display("FAIL ord_op%0d: got ar=%h br=%h want ar=%h br=%h", j, en_ar_q[j], en_br_q[j], 16'(j + 1), 16'(((j % 4) + 1) * 256)); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (y_r_s[i] !== exp_ord[i] || y_i_s[i] !== 16'h0000) begin errors++; $display("FAIL ord_y%0d: got %h+j%h want %h+j0000", i, y_r_s[i], y_i_s[i], exp_ord[i]); end
        end
    endtask

    initial begin
        checks = 0; errors = 0; tie_low = 1'b0; spurious = 1'b0;
        rst = 1'b1; start = 1'b0;
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_r = '0; a_wr_i = '0;
        x_wr_en = 1'b0; x_wr_addr = '0; x_wr_r = '0; x_wr_i = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_identity();
        test_all_ones();
        test_timeout();
        test_ignore_during_job();
        test_reset_mid_job();
        test_spurious_order();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmv_operand_seq.md
Name: cmv_operand_seq

Overview:
- Upstream sequencer for c_mac: computes y = A·x for a ROWS×K complex matrix A and a K-element complex vector x, both in Q-format fixed point.
- Holds A and x in internal register files loaded through write ports.
- On start, streams K operand pairs per row into c_mac and clears the accumulator before each row.
- Captures each row result from c_mac and presents it on a result port, with done and error status.

Parameters:
- N, 16, operand/result word width (two's complement, Q-format owned by c_mac).
- ROWS, 4, number of matrix rows (range 1..16).
- K, 4, terms per row; fixed at 4 to match the c_mac group counter.
- TIMEOUT, 32, maximum cycles spent in WAIT before error.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin job; sampled in IDLE only.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at job end.
- error  out  1  sticky timeout flag; cleared by the next accepted start.
- a_wr_en  in  1  matrix write strobe.
- a_wr_addr  in  clog2(ROWS*K)  matrix index row*K+k.
- a_wr_r, a_wr_i  in  N each  matrix element.
- x_wr_en  in  1  vector write strobe.
- x_wr_addr  in  clog2(K)  vector index.
- x_wr_r, x_wr_i  in  N each  vector element.
- mac_clear  out  1  to c_mac.
- mac_en  out  1  to c_mac.
- out_ar, out_ai, out_br, out_bi  out  N each  operands to c_mac.
- mac_result_valid  in  1  from c_mac.
- mac_r_in, mac_i_in  in  N each  c_mac outputs; valid one cycle after mac_result_valid.
- y_valid  out  1  one-cycle result strobe.
- y_idx  out  clog2(ROWS)  row index of the result.
- y_r, y_i  out  N each  row result.

Behaviour:
- Reset values: all outputs 0; state IDLE; register files 0; row and k counters 0.
- Writes land only when busy=0; writes while busy are ignored. Out-of-range addresses are ignored.
- All outputs are registered Moore decodes of state. No combinational path from any input to any output.
- FSM:
  - IDLE: start=1 → CLEAR; clear error; row=0.
  - CLEAR: mac_clear=1 for exactly 1 cycle → ISSUE with k=0.
  - ISSUE: mac_en=1 for K consecutive cycles. out_a = A[row*K+k], out_b = x[k], with k=0..K-1 in order. After k=K-1 → WAIT with timer=0.
  - WAIT: mac_result_valid=1 → CAPT. Otherwise timer++. Reaching timer=TIMEOUT → ERR.
  - CAPT: sample mac_r_in/mac_i_in. Next cycle: y_valid=1, y_idx=row, y_r/y_i = sampled values. If row=ROWS-1 → DONE, else row++ → CLEAR.
  - DONE: done=1 for 1 cycle → IDLE.
  - ERR: error=1 (sticky) → IDLE. No done pulse.
- Operand outputs are 0 whenever mac_en=0.
- mac_clear and mac_en are never high in the same cycle.
- mac_result_valid outside WAIT is ignored.
- start outside IDLE is ignored.
- y_r/y_i hold their value between strobes.
- Timing with c_mac latency 6 (start high in cycle 0):
  - mac_clear in cycle 1; mac_en in cycles 2–5.
  - mac_result_valid in cycle 11; CAPT in cycle 12; y_valid in cycle 13.
  - Next row's mac_clear also in cycle 13.
  - Row period is 12 cycles. For ROWS=4: last y_valid and done both in cycle 49; busy high in cycles 1–49.
- Asynchronous rst mid-job: returns to IDLE immediately and zeroes all outputs including error. The register files are also zeroed and must be reloaded.
- No internal arithmetic: results pass through unchanged from c_mac.

Test Plan:
- Identity A (diagonal real elements 0x0100 = 1.0, Q=8), x = {1,2,3,4}·0x0100 real, paired with c_mac → four y_valid strobes in cycles 13/25/37/49, idx 0..3, y_r = 0x0100, 0x0200, 0x0300, 0x0400, y_i = 0; done in cycle 49.
- All A = 0x0100 + j0x0100, all x = 0x0100 + j0 → every row gives y_r = 0x0400, y_i = 0x0400; mac_clear observed exactly once per row, before the first mac_en of that row.
- mac_result_valid tied low → after 4 mac_en cycles plus 32 WAIT cycles, error=1, busy=0, no done and no y_valid. A subsequent start clears error.
- start pulsed again and A/x written during the job → no effect: results match the first load and only one done pulse.
- rst asserted in cycle 7 (during WAIT) → outputs 0 immediately; after release, reload and start → correct results; no stale accumulation appears in y_r/y_i.
- Spurious mac_result_valid during ISSUE → ignored; operand order A[r*K+0..3] checked cycle-by-cycle on out_ar/out_br.
